alu_op_sequencer: RTL and testbench

Upstream issue stage for the 16-bit ALU. It buffers instruction words (opcode plus two operands) in a small FIFO and drives one instruction at a time onto the ALU operand/opcode inputs. It holds those inputs stable across the ALU's registered-flag edge, then captures the accumulator value and the two flags into a result register with a valid/ready handshake. An optional chaining mode feeds the previous result back as operand A.

---
 rtl/alu_op_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 16-bit ALU: instruction FIFO, fixed 3-cycle issue/capture FSM and result handshake.
// Optional operand chaining from the last result is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iInstValid,
  output logic             oInstReady,
  input  logic [2:0]       iInstOpcode,
  input  logic [WIDTH-1:0] iInstA,
  input  logic [WIDTH-1:0] iInstB,
  input  logic             iInstUseAcc,
  output logic [WIDTH-1:0] oA,
  output logic [WIDTH-1:0] oB,
  output logic [2:0]       oOpcode,
  input  logic [WIDTH-1:0] iAccumulator,
  input  logic             iCarryFlag,
  input  logic             iZeroFlag,
  output logic             oResValid,
  input  logic             iResReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oResCarry,
  output logic             oResZero,
  output logic             oBusy
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} state_t;

  typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
    logic             use_acc;
`endif
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  state_t           state;
  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] issue_a;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push       = iInstValid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign oInstReady = !full;
  assign oBusy      = (state != IDLE) || !empty;
  assign head       = mem[rd_ptr];

  always_comb begin
    wr_entry.opcode = iInstOpcode;
    wr_entry.a      = iInstA;
    wr_entry.b      = iInstB;
`ifdef ALU_SEQ_CHAIN_EN
    wr_entry.use_acc = iInstUseAcc;
`endif
  end

`ifdef ALU_SEQ_CHAIN_EN
  logic [WIDTH-1:0] acc;

  // Last captured result, tracked alongside oResult for operand chaining.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      acc <= '0;
    end else if (state == EXEC1) begin
      acc <= iAccumulator;
    end
  end

  assign issue_a = head.use_acc ? acc : head.a;
`else
  logic unused_use_acc;
  assign unused_use_acc = iInstUseAcc;
  assign issue_a        = head.a;
`endif

  // Storage is not reset; validity is carried by count.
  always_ff @(posedge iClock) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Operands are held through EXEC1 so the ALU flag flops see the same instruction as the capture.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state     <= IDLE;
      oA        <= '0;
      oB        <= '0;
      oOpcode   <= 3'b000;
      oResult   <= '0;
      oResCarry <= 1'b0;
      oResZero  <= 1'b0;
      oResValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            oA      <= issue_a;
            oB      <= head.b;
            oOpcode <= head.opcode;
            state   <= EXEC1;
          end
        end
        EXEC1: begin
          oResult <= iAccumulator;
          state   <= EXEC2;
        end
        EXEC2: begin
          oResCarry <= iCarryFlag;
          oResZero  <= iZeroFlag;
          oResValid <= 1'b1;
          oA        <= '0;
          oB        <= '0;
          oOpcode   <= 3'b000;
          state     <= DONE;
        end
        DONE: begin
          if (iResReady) begin
            oResValid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, scoreboard of expected results, vector table and corner sequences.
module tb_alu_op_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ua;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
  } exp_t;

  logic             iClock;
  logic             iReset;
  logic             iInstValid;
  logic             oInstReady;
  logic [2:0]       iInstOpcode;
  logic [WIDTH-1:0] iInstA;
  logic [WIDTH-1:0] iInstB;
  logic             iInstUseAcc;
  logic [WIDTH-1:0] oA;
  logic [WIDTH-1:0] oB;
  logic [2:0]       oOpcode;
  logic [WIDTH-1:0] iAccumulator;
  logic             iCarryFlag;
  logic             iZeroFlag;
  logic             oResValid;
  logic             iResReady;
  logic [WIDTH-1:0] oResult;
  logic             oResCarry;
  logic             oResZero;
  logic             oBusy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hs     = 0;
  int   cyc      = 0;
  int   prev_hs  = 0;
  bit   have_prev = 0;
  bit   chk_tput  = 0;
  exp_t sb [$];
  exp_t mon_e;
  vec_t tbl [10];
  logic [16:0] alu_full;

  alu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .iClock(iClock), .iReset(iReset),
    .iInstValid(iInstValid), .oInstReady(oInstReady),
    .iInstOpcode(iInstOpcode), .iInstA(iInstA), .iInstB(iInstB), .iInstUseAcc(iInstUseAcc),
    .oA(oA), .oB(oB), .oOpcode(oOpcode),
    .iAccumulator(iAccumulator), .iCarryFlag(iCarryFlag), .iZeroFlag(iZeroFlag),
    .oResValid(oResValid), .iResReady(iResReady),
    .oResult(oResult), .oResCarry(oResCarry), .oResZero(oResZero), .oBusy(oBusy)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;
  always @(posedge iClock) cyc <= cyc + 1;

  // Behavioural ALU: combinational result, flags registered from the same operands.
  function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  alu_fn = {1'b0, a & b};
      3'b001:  alu_fn = {1'b0, a | b};
      3'b010:  alu_fn = {1'b0, a ^ b};
      3'b011:  alu_fn = {1'b0, ~a};
      3'b100:  alu_fn = {1'b0, a};
      3'b101:  alu_fn = {1'b0, a} + {1'b0, b};
      3'b110:  alu_fn = {1'b0, a} - {1'b0, b};
      default: alu_fn = {1'b0, a} + 17'd1;
    endcase
  endfunction

  always_comb alu_full = alu_fn(oOpcode, oA, oB);
  assign iAccumulator = alu_full[15:0];

  always @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      iCarryFlag <= 1'b0;
      iZeroFlag  <= 1'b0;
    end else begin
      iCarryFlag <= alu_full[16];
      iZeroFlag  <= (alu_full[15:0] == 16'h0000);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic ua, input logic [15:0] res, input logic c, input logic z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ua = ua; v.res = res; v.c = c; v.z = z;
    return v;
  endfunction

  // Result monitor: every handshake pops the oldest expectation.
  always @(negedge iClock) begin
    if (iReset === 1'b1 && oResValid === 1'b1 && iResReady === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(1), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check("result",       32'(oResult),   32'(mon_e.res));
        check("result_carry", 32'(oResCarry), 32'(mon_e.c));
        check("result_zero",  32'(oResZero),  32'(mon_e.z));
      end
      if (chk_tput) begin
        if (have_prev) check("throughput", 32'(cyc - prev_hs), 32'(4));
        prev_hs   = cyc;
        have_prev = 1'b1;
      end
      n_hs++;
    end
  end

  task automatic push(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    iInstValid  = 1'b1;
    iInstOpcode = v.op;
    iInstA      = v.a;
    iInstB      = v.b;
    iInstUseAcc = v.ua;
    while (!oInstReady && n < 100) begin
      @(posedge iClock); #1;
      n++;
    end
    if (n >= 100) begin
      check("push_timeout", 32'(1), 32'(0));
      iInstValid = 1'b0;
      return;
    end
    @(posedge iClock);
    e.res = v.res; e.c = v.c; e.z = v.z;
    sb.push_back(e);
    #1 iInstValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || oBusy) && n < 500) begin
      @(posedge iClock); #1;
      n++;
    end
    check(name, 32'(n >= 500), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   accepted;
    int   hs0;
    int   n;
    vec_t v;
    bit   rdy;

    iReset = 1'b1; iInstValid = 1'b0; iInstOpcode = 3'b000; iInstA = '0; iInstB = '0;
    iInstUseAcc = 1'b0; iResReady = 1'b1;

    tbl[0] = mk(3'b101, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    tbl[1] = mk(3'b000, 16'h00F0, 16'h0F00, 1'b0, 16'h0000, 1'b0, 1'b1);
    tbl[2] = mk(3'b001, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0);
    tbl[3] = mk(3'b101, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    tbl[4] = mk(3'b110, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    tbl[5] = mk(3'b110, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    tbl[6] = mk(3'b010, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b1);
    tbl[7] = mk(3'b011, 16'h00FF, 16'h1234, 1'b0, 16'hFF00, 1'b0, 1'b0);
    tbl[8] = mk(3'b111, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1);
    tbl[9] = mk(3'b100, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0);

    // Reset values, observed while reset is held.
    #2 iReset = 1'b0;
    #1;
    check("rst_oA",         32'(oA),         32'(0));
    check("rst_oB",         32'(oB),         32'(0));
    check("rst_oOpcode",    32'(oOpcode),    32'(0));
    check("rst_oResult",    32'(oResult),    32'(0));
    check("rst_oResCarry",  32'(oResCarry),  32'(0));
    check("rst_oResZero",   32'(oResZero),   32'(0));
    check("rst_oResValid",  32'(oResValid),  32'(0));
    check("rst_oBusy",      32'(oBusy),      32'(0));
    check("rst_oInstReady", 32'(oInstReady), 32'(1));
    repeat (2) @(posedge iClock);
    #1 iReset = 1'b1;
    @(posedge iClock); #1;

    // First instruction: issue, capture and valid latency from the pop edge.
    push(mk(3'b101, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0));
    @(posedge iClock); #1;
    check("issue_oA",       32'(oA),        32'(16'h0003));
    check("issue_oB",       32'(oB),        32'(16'h0004));
    check("issue_oOpcode",  32'(oOpcode),   32'(3'b101));
    check("issue_busy",     32'(oBusy),     32'(1));
    @(posedge iClock); #1;
    check("edge1_oResult",  32'(oResult),   32'(16'h0007));
    check("edge1_valid",    32'(oResValid), 32'(0));
    @(posedge iClock); #1;
    check("edge2_valid",    32'(oResValid), 32'(1));
    check("edge2_oA_idle",  32'(oA),        32'(0));
    check("edge2_op_idle",  32'(oOpcode),   32'(0));
    drain("drain_first");

    // Vector table streamed back to back.
    for (int i = 0; i < 10; i++) push(tbl[i]);
    drain("drain_table");

    // Backpressure: results stalled, FIFO fills behind the first issued instruction.
    iResReady = 1'b0;
    accepted  = 0;
    for (int k = 0; k < int'(DEPTH) + 6; k++) begin
      if (accepted < int'(DEPTH) + 2) begin
        v = mk(3'b101, 16'(accepted + 1), 16'h0001, 1'b0, 16'(accepted + 2), 1'b0, 1'b0);
        iInstValid = 1'b1; iInstOpcode = v.op; iInstA = v.a; iInstB = v.b; iInstUseAcc = 1'b0;
        rdy = oInstReady;
        @(posedge iClock);
        if (rdy) begin
          mon_e.res = v.res; mon_e.c = v.c; mon_e.z = v.z;
          sb.push_back(mon_e);
          accepted++;
        end
        #1;
      end
    end
    iInstValid = 1'b0;
    check("bp_accepted",    32'(accepted),   32'(DEPTH + 1));
    check("bp_ready_low",   32'(oInstReady), 32'(0));
    check("bp_valid",       32'(oResValid),  32'(1));
    check("bp_result",      32'(oResult),    32'(16'h0002));
    repeat (3) @(posedge iClock);
    #1;
    check("bp_valid_hold",  32'(oResValid),  32'(1));
    check("bp_result_hold", 32'(oResult),    32'(16'h0002));
    hs0 = n_hs;
    have_prev = 1'b0;
    chk_tput  = 1'b1;
    iResReady = 1'b1;
    drain("drain_backpressure");
    chk_tput = 1'b0;
    check("bp_handshakes",  32'(n_hs - hs0), 32'(DEPTH + 1));
    check("bp_busy_low",    32'(oBusy),      32'(0));

    // Chaining: second issue takes operand A from the first result when enabled.
    push(mk(3'b101, 16'h0005, 16'h0002, 1'b0, 16'h0007, 1'b0, 1'b0));
    drain("drain_chain1");
`ifdef ALU_SEQ_CHAIN_EN
    push(mk(3'b101, 16'hFFFF, 16'h0001, 1'b1, 16'h0008, 1'b0, 1'b0));
    @(posedge iClock); #1;
    check("chain_oA", 32'(oA), 32'(16'h0007));
`else
    push(mk(3'b101, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1));
    @(posedge iClock); #1;
    check("chain_oA", 32'(oA), 32'(16'hFFFF));
`endif
    drain("drain_chain2");

    // Reset mid-operation: stall one result, fill the FIFO, issue one more, then reset in EXEC1.
    iResReady = 1'b0;
    push(mk(3'b101, 16'h0010, 16'h0001, 1'b0, 16'h0011, 1'b0, 1'b0));
    n = 0;
    while (!oResValid && n < 20) begin
      @(posedge iClock); #1;
      n++;
    end
    check("rst_seq_wait_valid", 32'(n >= 20), 32'(0));
    for (int k = 2; k <= 5; k++) push(mk(3'b010, 16'(k), 16'h0000, 1'b0, 16'(k), 1'b0, 1'b0));
    check("rst_seq_full", 32'(oInstReady), 32'(0));
    iResReady = 1'b1;
    @(posedge iClock); #1;
    iResReady = 1'b0;
    @(posedge iClock); #1;
    check("rst_seq_exec1_op", 32'(oOpcode), 32'(3'b010));
    check("rst_seq_exec1_oA", 32'(oA),      32'(16'h0002));
    iReset = 1'b0;
    sb.delete();
    #1;
    check("async_oA",         32'(oA),         32'(0));
    check("async_oOpcode",    32'(oOpcode),    32'(0));
    check("async_oResult",    32'(oResult),    32'(0));
    check("async_oResValid",  32'(oResValid),  32'(0));
    check("async_oBusy",      32'(oBusy),      32'(0));
    check("async_oInstReady", 32'(oInstReady), 32'(1));
    repeat (2) @(posedge iClock);
    #1 iReset = 1'b1;
    iResReady = 1'b1;
    repeat (10) @(posedge iClock);
    #1;
    check("post_rst_busy",    32'(oBusy),     32'(0));
    check("post_rst_opcode",  32'(oOpcode),   32'(0));
    check("post_rst_oA",      32'(oA),        32'(0));
    check("post_rst_valid",   32'(oResValid), 32'(0));
    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
